// File: rtl/axi4_buffer.sv
// axi4_buffer: single-clock AXI4 buffer with one FIFO per channel and caps
// on outstanding write/read bursts.
//
// Ports
//   clk_i, rst_i          : clock, asynchronous active-high reset
//   inport_aw*/w*/ar*     : upstream request channels (master side, inputs)
//   inport_b*/r*          : upstream response channels (master side, outputs)
//   outport_aw*/w*/ar*    : downstream request channels (slave side, outputs)
//   outport_b*/r*         : downstream response channels (slave side, inputs)

// axi4_buffer_fifo: registered-flag FIFO; payload presented from the head entry.
//   valid_i/data_i/ready_o : write side
//   valid_o/data_o/ready_i : read side
module axi4_buffer_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             ready_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    input  logic             ready_i
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_ready;
    logic             r_valid;

    logic             w_push;
    logic             w_pop;
    logic [CNT_W-1:0] w_count_nxt;

    assign w_push  = valid_i && r_ready;
    assign w_pop   = r_valid && ready_i;
    assign ready_o = r_ready;
    assign valid_o = r_valid;
    assign data_o  = r_mem[r_rd_ptr];

    // Occupancy after this cycle's push/pop; push+pop leaves it unchanged.
    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CNT_W'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - CNT_W'(1);
        end
    end

    // Storage, pointers and registered full/empty flags. Storage is cleared
    // on reset so payload outputs read as zero while in reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ready  <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= data_i;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_count_nxt;
            r_ready <= (w_count_nxt != CNT_W'(DEPTH));
            r_valid <= (w_count_nxt != CNT_W'(0));
        end
    end
endmodule

module axi4_buffer #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ID_W     = 4,
    parameter int unsigned AW_DEPTH = 2,
    parameter int unsigned W_DEPTH  = 4,
    parameter int unsigned B_DEPTH  = 2,
    parameter int unsigned AR_DEPTH = 2,
    parameter int unsigned R_DEPTH  = 4,
    parameter int unsigned MAX_WR   = 4,
    parameter int unsigned MAX_RD   = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,

    input  logic                inport_awvalid_i,
    input  logic [ADDR_W-1:0]   inport_awaddr_i,
    input  logic [ID_W-1:0]     inport_awid_i,
    input  logic [7:0]          inport_awlen_i,
    input  logic [1:0]          inport_awburst_i,
    output logic                inport_awready_o,

    input  logic                inport_wvalid_i,
    input  logic [DATA_W-1:0]   inport_wdata_i,
    input  logic [DATA_W/8-1:0] inport_wstrb_i,
    input  logic                inport_wlast_i,
    output logic                inport_wready_o,

    output logic                inport_bvalid_o,
    output logic [1:0]          inport_bresp_o,
    output logic [ID_W-1:0]     inport_bid_o,
    input  logic                inport_bready_i,

    input  logic                inport_arvalid_i,
    input  logic [ADDR_W-1:0]   inport_araddr_i,
    input  logic [ID_W-1:0]     inport_arid_i,
    input  logic [7:0]          inport_arlen_i,
    input  logic [1:0]          inport_arburst_i,
    output logic                inport_arready_o,

    output logic                inport_rvalid_o,
    output logic [DATA_W-1:0]   inport_rdata_o,
    output logic [1:0]          inport_rresp_o,
    output logic [ID_W-1:0]     inport_rid_o,
    output logic                inport_rlast_o,
    input  logic                inport_rready_i,

    output logic                outport_awvalid_o,
    output logic [ADDR_W-1:0]   outport_awaddr_o,
    output logic [ID_W-1:0]     outport_awid_o,
    output logic [7:0]          outport_awlen_o,
    output logic [1:0]          outport_awburst_o,
    input  logic                outport_awready_i,

    output logic                outport_wvalid_o,
    output logic [DATA_W-1:0]   outport_wdata_o,
    output logic [DATA_W/8-1:0] outport_wstrb_o,
    output logic                outport_wlast_o,
    input  logic                outport_wready_i,

    input  logic                outport_bvalid_i,
    input  logic [1:0]          outport_bresp_i,
    input  logic [ID_W-1:0]     outport_bid_i,
    output logic                outport_bready_o,

    output logic                outport_arvalid_o,
    output logic [ADDR_W-1:0]   outport_araddr_o,
    output logic [ID_W-1:0]     outport_arid_o,
    output logic [7:0]          outport_arlen_o,
    output logic [1:0]          outport_arburst_o,
    input  logic                outport_arready_i,

    input  logic                outport_rvalid_i,
    input  logic [DATA_W-1:0]   outport_rdata_i,
    input  logic [1:0]          outport_rresp_i,
    input  logic [ID_W-1:0]     outport_rid_i,
    input  logic                outport_rlast_i,
    output logic                outport_rready_o
);
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned AX_W   = ADDR_W + ID_W + 8 + 2;
    localparam int unsigned W_W    = DATA_W + STRB_W + 1;
    localparam int unsigned B_W    = 2 + ID_W;
    localparam int unsigned R_W    = DATA_W + 2 + ID_W + 1;
    localparam int unsigned CNT_W  = 8;

    logic [AX_W-1:0]  w_aw_data;
    logic             w_aw_valid;
    logic [AX_W-1:0]  w_ar_data;
    logic             w_ar_valid;
    logic             w_wr_ok;
    logic             w_rd_ok;
    logic             w_wr_inc;
    logic             w_wr_dec;
    logic             w_rd_inc;
    logic             w_rd_dec;
    logic [CNT_W-1:0] w_wr_cnt_nxt;
    logic [CNT_W-1:0] w_rd_cnt_nxt;
    logic [CNT_W-1:0] r_wr_cnt;
    logic [CNT_W-1:0] r_rd_cnt;

    // AW: held in the FIFO until the write limiter lets it through.
    axi4_buffer_fifo #(.WIDTH(AX_W), .DEPTH(AW_DEPTH)) u_aw_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (inport_awvalid_i),
        .data_i  ({inport_awaddr_i, inport_awid_i, inport_awlen_i, inport_awburst_i}),
        .ready_o (inport_awready_o),
        .valid_o (w_aw_valid),
        .data_o  (w_aw_data),
        .ready_i (outport_awready_i && w_wr_ok)
    );
    assign outport_awvalid_o = w_aw_valid && w_wr_ok;
    assign {outport_awaddr_o, outport_awid_o, outport_awlen_o, outport_awburst_o} = w_aw_data;

    // W: ungated, may run ahead of or behind AW.
    axi4_buffer_fifo #(.WIDTH(W_W), .DEPTH(W_DEPTH)) u_w_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (inport_wvalid_i),
        .data_i  ({inport_wdata_i, inport_wstrb_i, inport_wlast_i}),
        .ready_o (inport_wready_o),
        .valid_o (outport_wvalid_o),
        .data_o  ({outport_wdata_o, outport_wstrb_o, outport_wlast_o}),
        .ready_i (outport_wready_i)
    );

    // B: slave to master.
    axi4_buffer_fifo #(.WIDTH(B_W), .DEPTH(B_DEPTH)) u_b_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (outport_bvalid_i),
        .data_i  ({outport_bresp_i, outport_bid_i}),
        .ready_o (outport_bready_o),
        .valid_o (inport_bvalid_o),
        .data_o  ({inport_bresp_o, inport_bid_o}),
        .ready_i (inport_bready_i)
    );

    // AR: held in the FIFO until the read limiter lets it through.
    axi4_buffer_fifo #(.WIDTH(AX_W), .DEPTH(AR_DEPTH)) u_ar_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (inport_arvalid_i),
        .data_i  ({inport_araddr_i, inport_arid_i, inport_arlen_i, inport_arburst_i}),
        .ready_o (inport_arready_o),
        .valid_o (w_ar_valid),
        .data_o  (w_ar_data),
        .ready_i (outport_arready_i && w_rd_ok)
    );
    assign outport_arvalid_o = w_ar_valid && w_rd_ok;
    assign {outport_araddr_o, outport_arid_o, outport_arlen_o, outport_arburst_o} = w_ar_data;

    // R: slave to master.
    axi4_buffer_fifo #(.WIDTH(R_W), .DEPTH(R_DEPTH)) u_r_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (outport_rvalid_i),
        .data_i  ({outport_rdata_i, outport_rresp_i, outport_rid_i, outport_rlast_i}),
        .ready_o (outport_rready_o),
        .valid_o (inport_rvalid_o),
        .data_o  ({inport_rdata_o, inport_rresp_o, inport_rid_o, inport_rlast_o}),
        .ready_i (inport_rready_i)
    );

    // Outstanding-burst accounting: a burst is open from its downstream
    // address handshake until its upstream response (B, or R with last).
    assign w_wr_ok  = (r_wr_cnt < CNT_W'(MAX_WR));
    assign w_rd_ok  = (r_rd_cnt < CNT_W'(MAX_RD));
    assign w_wr_inc = outport_awvalid_o && outport_awready_i;
    assign w_wr_dec = inport_bvalid_o && inport_bready_i;
    assign w_rd_inc = outport_arvalid_o && outport_arready_i;
    assign w_rd_dec = inport_rvalid_o && inport_rready_i && inport_rlast_o;

    // Next counts; a decrement at zero is dropped so counters never wrap.
    always_comb begin
        w_wr_cnt_nxt = r_wr_cnt;
        w_rd_cnt_nxt = r_rd_cnt;
        if (w_wr_inc && !w_wr_dec) begin
            w_wr_cnt_nxt = r_wr_cnt + CNT_W'(1);
        end else if (!w_wr_inc && w_wr_dec && (r_wr_cnt != CNT_W'(0))) begin
            w_wr_cnt_nxt = r_wr_cnt - CNT_W'(1);
        end
        if (w_rd_inc && !w_rd_dec) begin
            w_rd_cnt_nxt = r_rd_cnt + CNT_W'(1);
        end else if (!w_rd_inc && w_rd_dec && (r_rd_cnt != CNT_W'(0))) begin
            w_rd_cnt_nxt = r_rd_cnt - CNT_W'(1);
        end
    end

    // Counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
        end else begin
            r_wr_cnt <= w_wr_cnt_nxt;
            r_rd_cnt <= w_rd_cnt_nxt;
        end
    end

    // A response with no burst outstanding indicates a misbehaving slave.
    a_wr_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(w_wr_dec && (r_wr_cnt == CNT_W'(0))));
    a_rd_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(w_rd_dec && (r_rd_cnt == CNT_W'(0))));
endmodule
